switch_edge_bank: RTL and testbench

//   Multi-channel successor to the single-switch rising-edge pulser. Each of N_CH raw

---
 rtl/switch_edge_bank.sv | 131 +++++++++++++
 tb/tb_switch_edge_bank.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_edge_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// switch_edge_bank
//   Bank of N_CH independent switch conditioners. Each raw input is
//   synchronised, debounced and turned into one-cycle event pulses. The pulse
//   polarity is chosen by EDGE_MODE. With REPEAT_EN set, a held switch also
//   emits auto-repeat pulses.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset (released synchronously)
//   en         1 = pulses enabled; 0 = pulses masked, filtering keeps running
//   switch_in  raw asynchronous switch inputs, one bit per channel
//   level_out  debounced level per channel
//   pulse_out  registered one-cycle event pulse per channel
//   any_pulse  OR of pulse_out in the same cycle
//
// There is no handshake here. pulse_out is a fire-and-forget strobe: a
// consumer that is not looking in that cycle misses it, and nothing is queued.
// Per-channel debug state (cnt, rcnt, phase_q) is reachable hierarchically
// under g_ch[i].
// ---------------------------------------------------------------------------
module switch_edge_bank #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] switch_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] pulse_out,
  output logic            any_pulse
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  // Repeat only makes sense when the press itself produces a pulse.
  localparam bit REP_ON = (REPEAT_EN == 1) && (EDGE_MODE != 1);

  assign any_pulse = |pulse_out;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          rcnt;
    logic                   level_q;
    logic                   pulse_q;
    logic                   phase_q;   // 0 = waiting for first repeat, 1 = periodic
    logic                   sync_bit;
    logic                   flip;
    logic                   rise;
    logic                   fall;
    logic                   edge_hit;
    logic                   rep_due;
    logic                   rep_hit;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // flip is true on the edge that commits a new debounced level, so the
    // registered pulse lands in the same cycle level_out first changes.
    assign flip = (sync_bit != level_q) && (cnt == DB_LAST);
    assign rise = flip & sync_bit;
    assign fall = flip & ~sync_bit;

    always_comb begin
      edge_hit = 1'b0;
      case (EDGE_MODE)
        0:       edge_hit = rise;
        1:       edge_hit = fall;
        default: edge_hit = flip;
      endcase
    end

    assign rep_due = phase_q ? (rcnt == RP_LAST) : (rcnt == RD_LAST);
    // A release landing on a repeat threshold wins: no repeat pulse.
    assign rep_hit = REP_ON && level_q && !fall && rep_due;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q  <= '0;
        cnt     <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        rcnt    <= '0;
        phase_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], switch_in[i]};

        if (sync_bit == level_q) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level_q <= sync_bit;
          cnt     <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end

        // en masks the pulse only; all counters below keep running.
        pulse_q <= en & (edge_hit | rep_hit);

        // While level is low (including the rising-edge cycle) the repeat
        // state sits cleared, so counting starts fresh from the press pulse.
        if (!REP_ON || !level_q || fall) begin
          rcnt    <= '0;
          phase_q <= 1'b0;
        end else if (rep_due) begin
          rcnt    <= '0;
          phase_q <= 1'b1;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
    end

    assign level_out[i] = level_q;
    assign pulse_out[i] = pulse_q;
  end

endmodule

// File: tb/tb_switch_edge_bank.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_switch_edge_bank
//   Four copies of switch_edge_bank driven from the same inputs:
//     m0: rising edge, no repeat     m1: falling edge, no repeat
//     m2: both edges, repeat on      m3: rising edge, repeat on
//   A behavioural model predicts level and pulses for every copy each cycle.
// ---------------------------------------------------------------------------
module tb_switch_edge_bank;
  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [N-1:0] sw;
  logic [N-1:0] lv [4];
  logic [N-1:0] pl [4];
  logic         ap [4];

  always #5 clk = ~clk;

  switch_edge_bank #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_m0 (
    .clk(clk), .rst_n(rst_n), .en(en), .switch_in(sw),
    .level_out(lv[0]), .pulse_out(pl[0]), .any_pulse(ap[0]));
  switch_edge_bank #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(1),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_m1 (
    .clk(clk), .rst_n(rst_n), .en(en), .switch_in(sw),
    .level_out(lv[1]), .pulse_out(pl[1]), .any_pulse(ap[1]));
  switch_edge_bank #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_m2 (
    .clk(clk), .rst_n(rst_n), .en(en), .switch_in(sw),
    .level_out(lv[2]), .pulse_out(pl[2]), .any_pulse(ap[2]));
  switch_edge_bank #(.N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_m3 (
    .clk(clk), .rst_n(rst_n), .en(en), .switch_in(sw),
    .level_out(lv[3]), .pulse_out(pl[3]), .any_pulse(ap[3]));

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int mode_of(input int k);
    case (k)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit rep_of(input int k);
    return (k >= 2);
  endfunction

  function automatic bit edge_match(input int mode, input bit r, input bit f);
    if (mode == 0) return r;
    if (mode == 1) return f;
    return r | f;
  endfunction

  // Pulses at DELAY, DELAY+PERIOD, ... cycles after the press pulse.
  function automatic bit rep_time(input int e);
    return (e == RD) || (e > RD && ((e - RD) % RP) == 0);
  endfunction

  // ---------------- reference model ----------------
  logic [19:0]  exp_q [$];
  logic [N-1:0] sw_hist [$];
  logic [N-1:0] m_level, sync_cur, new_level, rose, fell;
  logic [N-1:0] ep [4];
  int           run [N];
  int           t_rise [N];
  int           cyc;

  initial begin
    m_level = '0;
    cyc = 0;
    for (int c = 0; c < N; c++) begin run[c] = 0; t_rise[c] = 0; end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_level = '0;
        cyc = 0;
        for (int c = 0; c < N; c++) begin run[c] = 0; t_rise[c] = 0; end
        sw_hist.delete();
        exp_q.delete();
      end else begin
        // Value the last synchroniser stage presents to the debouncer now.
        sync_cur = (sw_hist.size() >= SS) ? sw_hist[sw_hist.size() - SS] : '0;
        new_level = m_level;
        for (int c = 0; c < N; c++) begin
          if (sync_cur[c] != m_level[c]) begin
            run[c]++;
            if (run[c] == DEB) begin
              new_level[c] = sync_cur[c];
              run[c] = 0;
            end
          end else begin
            run[c] = 0;
          end
        end
        cyc++;
        rose = new_level & ~m_level;
        fell = ~new_level & m_level;
        for (int c = 0; c < N; c++) if (rose[c]) t_rise[c] = cyc;
        for (int k = 0; k < 4; k++) begin
          for (int c = 0; c < N; c++) begin
            ep[k][c] = en && (edge_match(mode_of(k), rose[c], fell[c]) ||
                       (rep_of(k) && mode_of(k) != 1 && new_level[c] && !rose[c] &&
                        rep_time(cyc - t_rise[c])));
          end
        end
        exp_q.push_back({ep[3], ep[2], ep[1], ep[0], new_level});
        m_level = new_level;
        sw_hist.push_back(sw);
        if (sw_hist.size() > SS) void'(sw_hist.pop_front());
      end
    end
  end

  // ---------------- scoreboard / observation ----------------
  int          ncnt = 0;
  int          pc  [4][N];
  int          lp  [4][N];
  int          apc [4];
  logic [19:0] w;
  logic [3:0]  wp;

  initial begin
    for (int k = 0; k < 4; k++) begin
      apc[k] = 0;
      for (int c = 0; c < N; c++) begin pc[k][c] = 0; lp[k][c] = -1000; end
    end
    forever begin
      @(negedge clk);
      ncnt++;
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < N; c++) if (pl[k][c]) begin pc[k][c]++; lp[k][c] = ncnt; end
        if (ap[k]) apc[k]++;
      end
      if (rst_n && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
          wp = w[4 + 4*k +: 4];
          check($sformatf("m%0d_level", k), 32'(lv[k]), 32'(w[3:0]));
          check($sformatf("m%0d_pulse", k), 32'(pl[k]), 32'(wp));
          check($sformatf("m%0d_any", k), 32'(ap[k]), 32'(|wp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int t, b, b1, b2, ba;
  int hold [N];

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    sw    = '0;
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 4; k++) begin
      check("rst_level", 32'(lv[k]), 0);
      check("rst_pulse", 32'(pl[k]), 0);
      check("rst_any",   32'(ap[k]), 0);
    end
    step(2);
    rst_n = 1'b1;
    step(3);

    // Single press on ch0, held 20 cycles.
    b = pc[0][0];
    t = ncnt;
    sw[0] = 1'b1;
    step(20);
    check("t1_count", pc[0][0] - b, 1);
    check("t1_latency", lp[0][0] - t, 6);
    check("t1_others", pc[0][1] + pc[0][2] + pc[0][3], 0);
    sw[0] = 1'b0;
    step(12);

    // Bounce on ch1, runs of 1-3 cycles, then held.
    b = pc[0][1];
    sw[1] = 1'b1; step(2);
    sw[1] = 1'b0; step(1);
    sw[1] = 1'b1; step(3);
    sw[1] = 1'b0; step(2);
    sw[1] = 1'b1;
    t = ncnt;
    step(15);
    check("t2_count", pc[0][1] - b, 1);
    check("t2_latency", lp[0][1] - t, 6);
    sw[1] = 1'b0;
    step(12);

    // Press, hold 10, release on ch1 across edge modes.
    b = pc[0][1]; b1 = pc[1][1]; b2 = pc[2][1];
    sw[1] = 1'b1;
    step(10);
    sw[1] = 1'b0;
    t = ncnt;
    step(15);
    check("t3_rise_count", pc[0][1] - b, 1);
    check("t3_fall_count", pc[1][1] - b1, 1);
    check("t3_both_count", pc[2][1] - b2, 2);
    check("t3_fall_latency", lp[1][1] - t, 6);

    // Hold-to-repeat on ch2, then release.
    b = pc[3][2];
    sw[2] = 1'b1;
    t = ncnt;
    step(40);
    check("t4_hold_count", pc[3][2] - b, 6);
    check("t4_hold_last", lp[3][2] - t, 36);
    sw[2] = 1'b0;
    step(15);
    check("t4_release_count", pc[3][2] - b, 7);
    check("t4_release_last", lp[3][2] - t, 41);

    // Hold with en dropped mid-hold: cadence must continue underneath.
    b = pc[3][2];
    sw[2] = 1'b1;
    t = ncnt;
    step(12);
    en = 1'b0;
    b2 = pc[3][2];
    step(20);
    check("t4_masked", pc[3][2] - b2, 0);
    en = 1'b1;
    step(8);
    check("t4_resume", lp[3][2] - t, 36);
    sw[2] = 1'b0;
    step(15);
    check("t4_total", pc[3][2] - b, 3);

    // Simultaneous rise on ch0 and ch3.
    b = pc[0][0]; b1 = pc[0][3]; ba = apc[0];
    sw[0] = 1'b1; sw[3] = 1'b1;
    step(10);
    check("t5_ch0", pc[0][0] - b, 1);
    check("t5_ch3", pc[0][3] - b1, 1);
    check("t5_any", apc[0] - ba, 1);
    check("t5_same", lp[0][0], lp[0][3]);
    sw[0] = 1'b0;
    step(12);

    // Asynchronous reset while ch0 is mid-debounce and ch3 is high.
    sw[0] = 1'b1;
    step(4);
    check("t6_pre_level3", 32'(lv[0][3]), 1);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t6_async_level", 32'(lv[k]), 0);
      check("t6_async_pulse", 32'(pl[k]), 0);
      check("t6_async_any",   32'(ap[k]), 0);
    end
    step(1);
    rst_n = 1'b1;
    t = ncnt;
    step(10);
    check("t6_restart_latency", lp[0][0] - t, 6);

    // Randomised holds (mostly short bounces, some long holds) with en noise.
    for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 8);
    repeat (1200) begin
      step(1);
      for (int c = 0; c < N; c++) begin
        hold[c] = hold[c] - 1;
        if (hold[c] == 0) begin
          sw[c] = ~sw[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
        end
      end
      en = ($urandom_range(0, 15) != 0);
    end
    en = 1'b1;
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
